// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared result-bus types and CDB arbiter constants
package rv32i_types;

  localparam int ARCH_REG_BITS  = 5;
  localparam int ROB_ADDR_WIDTH = 5;
  localparam int CDB_FIFO_DEPTH = 2;

  localparam int FU_ADD = 0;
  localparam int FU_MUL = 1;
  localparam int FU_DIV = 2;
  localparam int FU_BR  = 3;

  typedef struct packed {
    logic                      valid;
    logic [ROB_ADDR_WIDTH-1:0] rob_idx;
    logic [ARCH_REG_BITS-1:0]  rd_s;
    logic [31:0]               rd_v;
  } cdb_t;

endpackage

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - per-FU result FIFO; storage unreset, flush clears pointers and count
module cdb_fifo
  import rv32i_types::*;
#(
  parameter int  DEPTH = CDB_FIFO_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  cdb_t          push_data,
  input  logic          pop,
  input  logic          flush,
  output cdb_t          head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  cdb_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload array is deliberately outside reset; only occupied slots are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - buffers FU results and round-robin serialises them onto the CDB
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH,
  parameter int NUM_FU     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  cdb_t              cdb_add,
  input  cdb_t              cdb_mul,
  input  cdb_t              cdb_div,
  input  cdb_t              cdb_br,
  input  logic              global_branch_signal,
  output logic [NUM_FU-1:0] fu_ready,
  output cdb_t              cdb_out,
  output logic [NUM_FU-1:0] grant,
  output logic              overflow_err
);

  localparam int RW = $clog2(NUM_FU);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  cdb_t              fu_in    [NUM_FU];
  cdb_t              fu_head  [NUM_FU];
  logic [CW-1:0]     fu_count [NUM_FU];
  logic [NUM_FU-1:0] fu_full, fu_empty, fu_push;

  logic [RW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              overflow_q, overflow_d;
  logic [RW-1:0]     win_idx, cand;
  logic              win_found;

  assign fu_in[FU_ADD] = cdb_add;
  assign fu_in[FU_MUL] = cdb_mul;
  assign fu_in[FU_DIV] = cdb_div;
  assign fu_in[FU_BR]  = cdb_br;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    assign fu_push[g]  = fu_in[g].valid && !global_branch_signal;
    assign fu_ready[g] = (fu_count[g] < CW'(FIFO_DEPTH));

    cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fu_push[g]),
      .push_data (fu_in[g]),
      .pop       (grant[g]),
      .flush     (global_branch_signal),
      .head      (fu_head[g]),
      .count     (fu_count[g]),
      .full      (fu_full[g]),
      .empty     (fu_empty[g])
    );
  end

  // Search starts at rr_ptr and wraps; the first non-empty FIFO wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 0; off < NUM_FU; off++) begin
      cand = rr_ptr_q + RW'(off);
      if (!win_found && !fu_empty[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    grant      = '0;
    cdb_out    = '0;
    rr_ptr_d   = rr_ptr_q;
    overflow_d = overflow_q | (|(fu_push & fu_full));
    if (win_found && !global_branch_signal) begin
      grant[win_idx] = 1'b1;
      cdb_out        = fu_head[win_idx];
      cdb_out.valid  = 1'b1;
      rr_ptr_d       = win_idx + RW'(1);
    end
  end

  assign overflow_err = overflow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
